max_scan_ctrl: RTL and testbench
================================

MAX_SCAN_CTRL -- requirements
Module: max_scan_ctrl

Interface
REQ-001 Parameter DATA_W, 32, operand width in bits.
REQ-002 Parameter LEN_W, 8, frame-length counter width; maximum frame length is 2^LEN_W-1.
REQ-003 Port clk  in  1  single clock; all state on rising edge.
REQ-004 Port rst_n  in  1  asynchronous active-low reset.
REQ-005 Port start  in  1  frame request; sampled only in IDLE.
REQ-006 Port len  in  LEN_W  frame length in words; sampled with start.
REQ-007 Port busy  out  1  high whenever state is not IDLE.
REQ-008 Port len_err  out  1  one-cycle pulse when start arrives with len==0.
REQ-009 Port in_valid  in  1  upstream word valid.
REQ-010 Port in_ready  out  1  high only in ACCUM.
REQ-011 Port in_data  in  DATA_W  unsigned operand word.
REQ-012 Port out_valid  out  1  result valid; high only in DONE.
REQ-013 Port out_ready  in  1  downstream accept.
REQ-014 Port out_max  out  DATA_W  unsigned maximum of the frame.
REQ-015 Port out_idx  out  LEN_W  0-based position of the first occurrence of out_max.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCUM, DONE.
REQ-017 In IDLE, start=1 with len!=0 SHALL latch len, clear beat count and move to ACCUM next cycle.
REQ-018 In IDLE, start=1 with len==0 SHALL pulse len_err for one cycle and remain in IDLE.
REQ-019 In ACCUM, a beat is accepted when in_valid and in_ready are both high; no other cycle changes the accumulator.
REQ-020 The first accepted beat (count 0) SHALL load cur_max=in_data and cur_idx=0 unconditionally.
REQ-021 Each later beat SHALL replace cur_max/cur_idx only if in_data > cur_max, unsigned and strict, so ties keep the earlier index.
REQ-022 The beat count SHALL be LEN_W bits wide and incremented per accepted beat; it SHALL NOT wrap, because len is at most 2^LEN_W-1.
REQ-023 When the accepted beat is beat number len, the FSM SHALL enter DONE on the next edge, so out_valid rises one cycle after the last handshake.
REQ-024 In DONE, out_valid, out_max and out_idx SHALL hold stable until out_ready=1; the FSM then returns to IDLE on that edge.
REQ-025 start SHALL be ignored outside IDLE, including the DONE/out_ready cycle; a new frame needs start after IDLE is reached.
REQ-026 in_valid SHALL be ignored outside ACCUM; stalls (in_valid=0) in ACCUM SHALL leave all state unchanged.
REQ-027 out_max/out_idx SHALL read 0 whenever out_valid=0.

Reset
REQ-028 rst_n low SHALL force IDLE immediately, clear cur_max, cur_idx, count and latched len, and drive busy=0, len_err=0, in_ready=0, out_valid=0, out_max=0, out_idx=0.
REQ-029 Reset in ACCUM or DONE SHALL discard the frame; no result is produced after release.

Structure
REQ-030 A shared package SHALL hold the DATA_W and LEN_W defaults and the state enum {IDLE, ACCUM, DONE}.
REQ-031 The comparison SHALL be a separate combinational sub-module max_cmp_u (a, b -> gt = a>b unsigned, max = gt ? a : b), instantiated once.

Verification
REQ-032 len=4, words 5,9,3,7 back-to-back, out_ready=1 -> out_valid one cycle after the 4th beat, out_max=9, out_idx=1, then IDLE.
REQ-033 len=3, words 0xFFFFFFFF,0x00000001,0xFFFFFFFF -> out_max=0xFFFFFFFF, out_idx=0 (tie keeps first; unsigned compare, not signed).
REQ-034 start with len=0 -> len_err high exactly one cycle, busy stays 0, in_ready stays 0.
REQ-035 len=2, in_valid gaps of 3 cycles, out_ready held low 5 cycles -> result 0 until handshake, out_valid/out_max stable throughout, start pulses during busy ignored.
REQ-036 rst_n asserted after beat 2 of len=5 -> all outputs 0 asynchronously; the next frame len=1, word 0x10 -> out_max=0x10, out_idx=0.

Source files
------------

// File: rtl/max_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// max_scan_ctrl_pkg
//   Shared definitions for the max-scan frame controller.
//   - DATA_W_DEF / LEN_W_DEF : default operand and frame-length widths
//   - state_e                : controller state encoding (IDLE, ACCUM, DONE)
// -----------------------------------------------------------------------------
package max_scan_ctrl_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : max_scan_ctrl_pkg

// File: rtl/max_scan_ctrl_max_cmp_u.sv
// -----------------------------------------------------------------------------
// max_cmp_u
//   Combinational unsigned comparator / selector.
//   Ports:
//     a   in  W  candidate operand
//     b   in  W  current maximum
//     gt  out 1  a > b (unsigned, strict)
//     max out W  gt ? a : b  (ties select b, i.e. the earlier value)
// -----------------------------------------------------------------------------
import max_scan_ctrl_pkg::*;

module max_cmp_u #(
  parameter int W = DATA_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt,
  output logic [W-1:0] max
);

  assign gt  = (a > b);
  assign max = gt ? a : b;

endmodule : max_cmp_u

// File: rtl/max_scan_ctrl.sv
// -----------------------------------------------------------------------------
// max_scan_ctrl
//   Scans a frame of len unsigned words and reports the maximum value and the
//   0-based index of its first occurrence.
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset
//     start, len           frame request and length (sampled in IDLE only)
//     busy                 high whenever not IDLE
//     len_err              one-cycle pulse after a start with len==0
//     in_valid/in_ready/in_data    input word stream (ready only in ACCUM)
//     out_valid/out_ready/out_max/out_idx  result (valid only in DONE)
// -----------------------------------------------------------------------------
import max_scan_ctrl_pkg::*;

module max_scan_ctrl #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              len_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [LEN_W-1:0]  out_idx
);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   cur_max_q, cur_max_d;
  logic [LEN_W-1:0]    cur_idx_q, cur_idx_d;
  logic                len_err_q, len_err_d;

  logic                cmp_gt;
  logic [DATA_W-1:0]   cmp_max;
  logic [LEN_W-1:0]    cnt_inc;

  max_cmp_u #(.W(DATA_W)) u_cmp (
    .a   (in_data),
    .b   (cur_max_q),
    .gt  (cmp_gt),
    .max (cmp_max)
  );

  // len never exceeds 2^LEN_W-1, so the incremented count cannot wrap
  // before it matches len_q.
  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    cur_max_d = cur_max_q;
    cur_idx_d = cur_idx_q;
    len_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            len_err_d = 1'b1;
          end else begin
            len_d     = len;
            cnt_d     = '0;
            cur_max_d = '0;
            cur_idx_d = '0;
            state_d   = ACCUM;
          end
        end
      end
      ACCUM: begin
        // in_ready is high throughout ACCUM, so in_valid alone is the handshake.
        if (in_valid) begin
          cnt_d = cnt_inc;
          if (cnt_q == '0) begin
            // First beat seeds the accumulator regardless of stale contents.
            cur_max_d = in_data;
            cur_idx_d = '0;
          end else if (cmp_gt) begin
            cur_max_d = cmp_max;
            cur_idx_d = cnt_q;
          end
          if (cnt_inc == len_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      cur_max_q <= '0;
      cur_idx_q <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      cur_max_q <= cur_max_d;
      cur_idx_q <= cur_idx_d;
      len_err_q <= len_err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign len_err   = len_err_q;
  // Result buses are forced to zero whenever no result is being offered.
  assign out_max   = out_valid ? cur_max_q : '0;
  assign out_idx   = out_valid ? cur_idx_q : '0;

endmodule : max_scan_ctrl

// File: tb/tb_max_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_max_scan_ctrl
//   Self-checking bench for max_scan_ctrl: directed scenarios plus randomized
//   frames compared against a behavioural max/first-index model.
// -----------------------------------------------------------------------------
module tb_max_scan_ctrl;

  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] len;
  logic          busy;
  logic          len_err;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_max;
  logic [LW-1:0] out_idx;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Words of the frame currently being driven.
  logic [DW-1:0] words[$];

  // Observations gathered by drive_frame.
  logic [DW-1:0] obs_max;
  logic [LW-1:0] obs_idx;
  bit            obs_lat_ok;
  bit            obs_stable;
  bit            obs_zero_before;
  bit            obs_busy_after;
  bit            obs_valid_after;
  bit            obs_timeout;

  always #5 clk = ~clk;

  max_scan_ctrl #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .len_err   (len_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx)
  );

  // Reference: maximum value and index of its first occurrence.
  task automatic ref_model(output logic [DW-1:0] m, output logic [LW-1:0] idx);
    m   = words[0];
    idx = '0;
    foreach (words[i]) begin
      if (words[i] > m) begin
        m   = words[i];
        idx = LW'(i);
      end
    end
  endtask

  // Drives one frame from 'words'. Inputs change just after a falling edge and
  // outputs are sampled there too. gap = idle cycles before each beat, hold =
  // cycles out_ready stays low, poke = hammer start/in_valid while busy.
  task automatic drive_frame(input int gap, input int hold, input bit poke);
    logic [DW-1:0] m0;
    logic [LW-1:0] i0;
    int n;
    int w;
    n = words.size();
    obs_zero_before = 1'b1;
    obs_stable      = 1'b1;
    obs_timeout     = 1'b0;
    @(negedge clk);
    start = 1'b1;
    len   = LW'(n);
    @(negedge clk);
    start = 1'b0;
    len   = '0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        if (poke) begin
          start = 1'b1;
          len   = 8'd3;
        end
        @(negedge clk);
        start = 1'b0;
        if (out_valid !== 1'b0 || out_max !== '0 || out_idx !== '0)
          obs_zero_before = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = words[i];
      w = 0;
      while (in_ready !== 1'b1 && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) obs_timeout = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = $urandom;
      if (i != n - 1 && (out_valid !== 1'b0 || out_max !== '0 || out_idx !== '0))
        obs_zero_before = 1'b0;
    end
    obs_lat_ok = (out_valid === 1'b1);
    m0 = out_max;
    i0 = out_idx;
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        start    = 1'b1;
        len      = 8'd2;
        in_valid = 1'b1;
        in_data  = '1;
      end
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      if (out_valid !== 1'b1 || out_max !== m0 || out_idx !== i0)
        obs_stable = 1'b0;
    end
    out_ready = 1'b1;
    if (poke) begin
      start = 1'b1;
      len   = 8'd2;
    end
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    len       = '0;
    obs_busy_after  = busy;
    obs_valid_after = out_valid;
    obs_max = m0;
    obs_idx = i0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({busy, len_err, in_ready, out_valid} !== 4'b0 || out_max !== '0 || out_idx !== '0)
      $display("FAIL reset_outputs: got busy=%b len_err=%b in_ready=%b out_valid=%b max=%h idx=%0d, need all 0",
               busy, len_err, in_ready, out_valid, out_max, out_idx);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_idle: got busy=%b need 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    words = '{32'd5, 32'd9, 32'd3, 32'd7};
    drive_frame(0, 0, 1'b0);
    $display("basic frame: max=%0d idx=%0d", obs_max, obs_idx);
    chk_cnt++;
    if (obs_lat_ok !== 1'b1 || obs_timeout) $display("FAIL basic_latency: out_valid=%b one cycle after last beat, need 1", obs_lat_ok);
    else pass_cnt++;
    chk_cnt++;
    if (obs_max !== 32'd9 || obs_idx !== 8'd1)
      $display("FAIL basic_result: got max=%0d idx=%0d need max=9 idx=1", obs_max, obs_idx);
    else pass_cnt++;
    chk_cnt++;
    if (obs_busy_after !== 1'b0 || obs_valid_after !== 1'b0)
      $display("FAIL basic_idle: got busy=%b out_valid=%b after handshake, need 0/0", obs_busy_after, obs_valid_after);
    else pass_cnt++;
  endtask

  task automatic test_unsigned_tie();
    words = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
    drive_frame(0, 1, 1'b0);
    $display("unsigned/tie frame: max=%h idx=%0d", obs_max, obs_idx);
    chk_cnt++;
    if (obs_max !== 32'hFFFF_FFFF || obs_idx !== 8'd0)
      $display("FAIL unsigned_tie: got max=%h idx=%0d need max=ffffffff idx=0", obs_max, obs_idx);
    else pass_cnt++;
  endtask

  task automatic test_len_err();
    @(negedge clk);
    start = 1'b1;
    len   = '0;
    @(negedge clk);
    start = 1'b0;
    $display("len_err probe: len_err=%b busy=%b in_ready=%b", len_err, busy, in_ready);
    chk_cnt++;
    if (len_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL len_err_pulse: got len_err=%b busy=%b in_ready=%b need 1/0/0", len_err, busy, in_ready);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (len_err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL len_err_once: got len_err=%b busy=%b in_ready=%b need 0/0/0", len_err, busy, in_ready);
    else pass_cnt++;
  endtask

  task automatic test_stall_backpressure();
    words = '{32'd100, 32'd200};
    drive_frame(3, 5, 1'b1);
    $display("stall frame: max=%0d idx=%0d stable=%b", obs_max, obs_idx, obs_stable);
    chk_cnt++;
    if (obs_zero_before !== 1'b1) $display("FAIL stall_zero_before: result nonzero before DONE, need 0");
    else pass_cnt++;
    chk_cnt++;
    if (obs_stable !== 1'b1) $display("FAIL stall_hold_stable: result changed while out_ready low, need stable");
    else pass_cnt++;
    chk_cnt++;
    if (obs_max !== 32'd200 || obs_idx !== 8'd1)
      $display("FAIL stall_result: got max=%0d idx=%0d need max=200 idx=1", obs_max, obs_idx);
    else pass_cnt++;
    chk_cnt++;
    if (obs_busy_after !== 1'b0)
      $display("FAIL stall_start_ignored: got busy=%b after handshake with start high, need 0", obs_busy_after);
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    start = 1'b1;
    len   = 8'd5;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'd77;
    @(negedge clk);
    in_data  = 32'd88;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    $display("midframe reset: busy=%b in_ready=%b out_valid=%b", busy, in_ready, out_valid);
    chk_cnt++;
    if ({busy, len_err, in_ready, out_valid} !== 4'b0 || out_max !== '0 || out_idx !== '0)
      $display("FAIL async_reset: got busy=%b len_err=%b in_ready=%b out_valid=%b max=%h idx=%0d need all 0",
               busy, len_err, in_ready, out_valid, out_max, out_idx);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL reset_discard: got busy=%b out_valid=%b after release, need 0/0", busy, out_valid);
    else pass_cnt++;
    words = '{32'h10};
    drive_frame(0, 0, 1'b0);
    $display("post-reset frame: max=%h idx=%0d", obs_max, obs_idx);
    chk_cnt++;
    if (obs_lat_ok !== 1'b1 || obs_max !== 32'h10 || obs_idx !== 8'd0)
      $display("FAIL post_reset_frame: got valid=%b max=%h idx=%0d need 1/10/0", obs_lat_ok, obs_max, obs_idx);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [DW-1:0] em;
    logic [LW-1:0] ei;
    int n;
    for (int f = 0; f < 25; f++) begin
      n = (f == 0) ? 255 : int'($urandom_range(1, 12));
      words.delete();
      for (int k = 0; k < n; k++)
        words.push_back(($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom));
      ref_model(em, ei);
      drive_frame(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'(f % 2));
      $display("random frame %0d len=%0d: max=%h idx=%0d expect max=%h idx=%0d", f, n, obs_max, obs_idx, em, ei);
      chk_cnt++;
      if (obs_timeout || obs_lat_ok !== 1'b1 || obs_max !== em || obs_idx !== ei)
        $display("FAIL random_frame_%0d: got valid=%b max=%h idx=%0d need valid=1 max=%h idx=%0d",
                 f, obs_lat_ok, obs_max, obs_idx, em, ei);
      else pass_cnt++;
      chk_cnt++;
      if (obs_stable !== 1'b1 || obs_zero_before !== 1'b1 || obs_busy_after !== 1'b0)
        $display("FAIL random_protocol_%0d: got stable=%b zero_before=%b busy_after=%b need 1/1/0",
                 f, obs_stable, obs_zero_before, obs_busy_after);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_unsigned_tie();
    test_len_err();
    test_stall_backpressure();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_max_scan_ctrl
